ras_call_ret_detector: RTL

Front-end pipeline stage that sits directly upstream of `return_stack_buffer`. It classifies each fetched RV32 instruction as call, return, or coroutine swap using the standard RISC-V link-register hint rules. It drives the stack's push and pop strobes exactly once per accepted instruction. It registers the instruction toward decode together with a return-target prediction taken from the stack top.

---
 rtl/ras_call_ret_detector.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ras_call_ret_detector.sv
// ras_call_ret_detector
//
// Front-end stage directly upstream of return_stack_buffer. Each fetched
// RV32 instruction is classified as call, return or coroutine swap using
// the RISC-V link-register hints (x1/x5). The stage drives the stack push
// and pop strobes once per accepted instruction. It registers the
// instruction toward decode together with a return-target prediction
// taken from the stack top.
//
// Optional feature macro: RAS_COROUTINE_EN
//   defined   : coroutine swap (JALR rd=link, rs1=link, rd!=rs1) pops (if
//               the stack is non-empty) and pushes in the same cycle. The
//               stack turns this into replace-at-top. The popped top is
//               used as the prediction.
//   undefined : coroutine swap is treated as a plain push, with no
//               prediction.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   flush_i               redirect; kills stage contents, blocks accept
//   fetch_valid_i/ready_o upstream handshake
//   fetch_pc_i/instr_i    upstream payload
//   dec_valid_o/ready_i   downstream handshake
//   dec_pc_o/instr_o      registered payload
//   dec_pred_taken_o      return target predicted
//   dec_pred_target_o     predicted return target (0 when not taken)
//   rsb_push_en_o/addr_o  push strobe / return address (pc + 4)
//   rsb_pop_en_o          pop strobe
//   rsb_pop_addr_i        stack top
//   rsb_pop_valid_i       stack non-empty
//
// Handshake: a transfer happens on a rising edge where valid and ready
// are both high. Valid is never made dependent on ready. Payload is held
// stable while valid is high and ready is low. Upstream acceptance
// additionally requires flush_i low.
//
// State is visible as state_q (ST_EMPTY / ST_FULL) for checkers.

module ras_call_ret_detector #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,

  input  logic                  fetch_valid_i,
  output logic                  fetch_ready_o,
  input  logic [ADDR_WIDTH-1:0] fetch_pc_i,
  input  logic [31:0]           fetch_instr_i,

  output logic                  dec_valid_o,
  input  logic                  dec_ready_i,
  output logic [ADDR_WIDTH-1:0] dec_pc_o,
  output logic [31:0]           dec_instr_o,
  output logic                  dec_pred_taken_o,
  output logic [ADDR_WIDTH-1:0] dec_pred_target_o,

  output logic                  rsb_push_en_o,
  output logic [ADDR_WIDTH-1:0] rsb_push_addr_o,
  output logic                  rsb_pop_en_o,
  input  logic [ADDR_WIDTH-1:0] rsb_pop_addr_i,
  input  logic                  rsb_pop_valid_i
);

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e state_q, state_d;

  // ---------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic       is_jal;
  logic       is_jalr;
  logic       rd_link;
  logic       rs1_link;
  logic       coroutine_class;
  logic       push_class;
  logic       pop_class;

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  assign opcode   = fetch_instr_i[6:0];
  assign rd       = fetch_instr_i[11:7];
  assign funct3   = fetch_instr_i[14:12];
  assign rs1      = fetch_instr_i[19:15];

  assign is_jal   = (opcode == OPC_JAL);
  assign is_jalr  = (opcode == OPC_JALR) && (funct3 == 3'b000);
  assign rd_link  = is_link(rd);
  assign rs1_link = is_link(rs1);

  // Both registers are links but they differ. This is the coroutine swap
  // hint. When rd == rs1, the hint is a plain call.
  assign coroutine_class = is_jalr & rd_link & rs1_link & (rd != rs1);

  // Any link-writing JAL/JALR pushes. This includes the coroutine swap in
  // both build configurations.
  assign push_class = (is_jal | is_jalr) & rd_link;

`ifdef RAS_COROUTINE_EN
  assign pop_class = (is_jalr & ~rd_link & rs1_link) | coroutine_class;
`else
  assign pop_class = is_jalr & ~rd_link & rs1_link;
`endif

  // ---------------------------------------------------------------------
  // Handshake and stack strobes
  // ---------------------------------------------------------------------
  logic acc;
  logic pred_taken;

  // Reset forces ready low so that no strobe can leak out during reset.
  assign fetch_ready_o = ~rst_i & ~flush_i &
                         ((state_q == ST_EMPTY) | dec_ready_i);
  assign acc           = fetch_valid_i & fetch_ready_o & ~flush_i;

  // An empty stack on a return gives no pop and no prediction. The
  // instruction still passes through.
  assign pred_taken      = pop_class & rsb_pop_valid_i;

  assign rsb_push_en_o   = acc & push_class;
  assign rsb_pop_en_o    = acc & pred_taken;
  assign rsb_push_addr_o = fetch_pc_i + ADDR_WIDTH'(4);

  // ---------------------------------------------------------------------
  // Stage FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (acc) state_d = ST_FULL;
      end
      ST_FULL: begin
        // acc while FULL implies dec_ready_i, which means a reload.
        if (dec_ready_i && !acc) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush_i) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Payload registers: these load only on accept, so they hold through
  // stalls.
  // ---------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [31:0]           instr_q;
  logic                  taken_q;
  logic [ADDR_WIDTH-1:0] target_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q     <= '0;
      instr_q  <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
    end else if (acc) begin
      pc_q     <= fetch_pc_i;
      instr_q  <= fetch_instr_i;
      taken_q  <= pred_taken;
      target_q <= pred_taken ? rsb_pop_addr_i : '0;
    end
  end

  assign dec_valid_o       = (state_q == ST_FULL);
  assign dec_pc_o          = pc_q;
  assign dec_instr_o       = instr_q;
  assign dec_pred_taken_o  = taken_q;
  assign dec_pred_target_o = target_q;

endmodule
